// File: rtl/ring_osc_window_avg.sv
// Windowed ring-oscillator frequency meter: counts synchronized osc_in rising edges per
// WINDOW_CYCLES window, averages 2^AVG_LOG2 windows, holds the result under valid/ack.
module ring_osc_window_avg #(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned WINDOW_CYCLES = 1000,
  parameter int unsigned AVG_LOG2      = 3
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             osc_in,
  input  logic             avg_ack,
  output logic [WIDTH-1:0] avg_out,
  output logic             avg_valid,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned CycW = $clog2(WINDOW_CYCLES);
  localparam int unsigned IdxW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned AccW = WIDTH + AVG_LOG2;

  localparam logic [CycW-1:0]  CycLast = CycW'(WINDOW_CYCLES - 1);
  localparam logic [IdxW-1:0]  IdxLast = IdxW'((1 << AVG_LOG2) - 1);
  localparam logic [WIDTH-1:0] CntMax  = '1;

  typedef enum logic [1:0] {
    StIdle,
    StWindow,
    StHold
  } state_e;

  state_e state_q, state_d;

  logic             sync1_q, sync2_q, prev_q;
  logic             osc_rise;

  logic [CycW-1:0]  cyc_q, cyc_d;
  logic [WIDTH-1:0] win_cnt_q, win_cnt_d;
  logic [IdxW-1:0]  win_idx_q, win_idx_d;
  logic [AccW-1:0]  acc_q, acc_d;
  logic             acc_pend_q, acc_pend_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic [WIDTH-1:0] avg_out_q, avg_out_d;
  logic             avg_valid_q, avg_valid_d;
  logic             overflow_q, overflow_d;

  logic [AccW-1:0]  sum;
  logic [AccW-1:0]  sum_shr;
  logic [WIDTH-1:0] win_base;

  // osc_in is asynchronous: two-flop synchronizer, third flop for rising-edge detection.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= osc_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign osc_rise = sync2_q & ~prev_q;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cyc_q       <= '0;
      win_cnt_q   <= '0;
      win_idx_q   <= '0;
      acc_q       <= '0;
      acc_pend_q  <= 1'b0;
      ovf_pend_q  <= 1'b0;
      avg_out_q   <= '0;
      avg_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      win_cnt_q   <= win_cnt_d;
      win_idx_q   <= win_idx_d;
      acc_q       <= acc_d;
      acc_pend_q  <= acc_pend_d;
      ovf_pend_q  <= ovf_pend_d;
      avg_out_q   <= avg_out_d;
      avg_valid_q <= avg_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  // Running total including the window that just closed.
  assign sum     = acc_q + AccW'(win_cnt_q);
  assign sum_shr = sum >> AVG_LOG2;

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    win_cnt_d   = win_cnt_q;
    win_idx_d   = win_idx_q;
    acc_d       = acc_q;
    acc_pend_d  = acc_pend_q;
    ovf_pend_d  = ovf_pend_q;
    avg_out_d   = avg_out_q;
    avg_valid_d = avg_valid_q;
    overflow_d  = overflow_q;
    win_base    = win_cnt_q;

    unique case (state_q)
      StIdle: begin
        cyc_d      = '0;
        win_cnt_d  = '0;
        win_idx_d  = '0;
        acc_d      = '0;
        acc_pend_d = 1'b0;
        ovf_pend_d = 1'b0;
        if (en) begin
          state_d = StWindow;
        end
      end

      StWindow: begin
        if (!en) begin
          // Abort: partial window and accumulator are dropped, last result kept.
          state_d    = StIdle;
          cyc_d      = '0;
          win_cnt_d  = '0;
          win_idx_d  = '0;
          acc_d      = '0;
          acc_pend_d = 1'b0;
          ovf_pend_d = 1'b0;
        end else if (acc_pend_q && (win_idx_q == IdxLast)) begin
          avg_out_d   = sum_shr[WIDTH-1:0];
          overflow_d  = ovf_pend_q;
          avg_valid_d = 1'b1;
          state_d     = StHold;
          cyc_d       = '0;
          win_cnt_d   = '0;
          win_idx_d   = '0;
          acc_d       = '0;
          acc_pend_d  = 1'b0;
          ovf_pend_d  = 1'b0;
        end else begin
          // The accumulate cycle is also cycle 0 of the next window.
          if (acc_pend_q) begin
            acc_d     = sum;
            win_idx_d = win_idx_q + IdxW'(1);
            win_base  = '0;
          end
          win_cnt_d = win_base;
          if (osc_rise) begin
            if (win_base == CntMax) begin
              ovf_pend_d = 1'b1;
            end else begin
              win_cnt_d = win_base + WIDTH'(1);
            end
          end
          acc_pend_d = (cyc_q == CycLast);
          cyc_d      = (cyc_q == CycLast) ? '0 : cyc_q + CycW'(1);
        end
      end

      StHold: begin
        if (avg_ack) begin
          avg_valid_d = 1'b0;
          state_d     = en ? StWindow : StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign avg_out   = avg_out_q;
  assign avg_valid = avg_valid_q;
  assign overflow  = overflow_q;
  assign busy      = (state_q == StWindow) || (state_q == StHold);

endmodule

// File: tb/tb_ring_osc_window_avg.sv
// Directed bench for ring_osc_window_avg: a 16-bit instance for timing/averaging/handshake
// and a 4-bit instance for saturation.
module tb_ring_osc_window_avg;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        en;
  logic        osc_in;
  logic        avg_ack;
  logic [15:0] avg_out;
  logic        avg_valid;
  logic        overflow;
  logic        busy;

  logic        en4;
  logic        ack4;
  logic [3:0]  avg4;
  logic        valid4;
  logic        ovf4;
  logic        busy4;

  int n_cmp;
  int n_err;
  int osc_half;
  int osc_cnt;
  int cnt;

  always #5 clk_in = ~clk_in;

  ring_osc_window_avg #(
    .WIDTH        (16),
    .WINDOW_CYCLES(100),
    .AVG_LOG2     (2)
  ) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .en       (en),
    .osc_in   (osc_in),
    .avg_ack  (avg_ack),
    .avg_out  (avg_out),
    .avg_valid(avg_valid),
    .overflow (overflow),
    .busy     (busy)
  );

  ring_osc_window_avg #(
    .WIDTH        (4),
    .WINDOW_CYCLES(100),
    .AVG_LOG2     (2)
  ) dut4 (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .en       (en4),
    .osc_in   (osc_in),
    .avg_ack  (ack4),
    .avg_out  (avg4),
    .avg_valid(valid4),
    .overflow (ovf4),
    .busy     (busy4)
  );

  // One clock, sampled 1ns after the edge; osc_in toggles every osc_half cycles when nonzero.
  task automatic step();
    @(posedge clk_in);
    #1;
    osc_cnt++;
    if (osc_half != 0 && osc_cnt >= osc_half) begin
      osc_in  = ~osc_in;
      osc_cnt = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input bit use4, input int bound, output int n);
    n = 0;
    while (((use4 ? valid4 : avg_valid) !== 1'b1) && n < bound) begin
      step();
      n++;
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    avg_ack  = 1'b0;
    en4      = 1'b0;
    ack4     = 1'b0;
    osc_in   = 1'b0;
    osc_half = 5;
    osc_cnt  = 0;

    // Reset held with en high and osc_in toggling
    repeat (4) step();
    en = 1'b1;
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_valid", avg_valid, 0);
    chk("rst_out", avg_out, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst4_out", avg4, 0);
    chk("rst4_busy", busy4, 0);
    en    = 1'b0;
    rst_n = 1'b1;
    step();
    chk("idle_busy", busy, 0);

    // Period-10 oscillator: 10 edges in every 100-cycle window
    en = 1'b1;
    wait_valid(0, 500, cnt);
    chk("lat_first", cnt, 402);
    chk("avg_p10", avg_out inside {16'd9, 16'd10}, 1);
    chk("ovf_p10", overflow, 0);
    chk("busy_hold", busy, 1);

    // Result held for 500 cycles without ack, en low
    en = 1'b0;
    repeat (500) step();
    chk("hold_valid", avg_valid, 1);
    chk("hold_out", avg_out, 10);
    chk("hold_busy", busy, 1);
    avg_ack = 1'b1;
    step();
    avg_ack = 1'b0;
    chk("ack_valid", avg_valid, 0);
    chk("ack_idle", busy, 0);
    chk("ack_out_kept", avg_out, 10);

    // Floor rounding: 10,11,11,11 edges -> 43 >> 2 = 10
    osc_half = 0;
    osc_in   = 1'b0;
    repeat (5) step();
    en = 1'b1;
    for (int w = 0; w < 4; w++) begin
      for (int c = 0; c < 100; c++) begin
        int n;
        n = (w == 0) ? 10 : 11;
        osc_in = (c >= 5) && (c < 5 + 8 * n) && (((c - 5) % 8) < 4);
        step();
      end
    end
    wait_valid(0, 10, cnt);
    chk("floor_lat", cnt, 2);
    chk("floor_avg", avg_out, 10);
    chk("floor_ovf", overflow, 0);
    avg_ack = 1'b1;
    step();
    avg_ack = 1'b0;
    en      = 1'b0;
    step();
    chk("floor_idle", busy, 0);
    chk("floor_valid", avg_valid, 0);

    // Abort at cycle 250, then re-enable
    osc_half = 5;
    osc_cnt  = 0;
    en       = 1'b1;
    repeat (250) step();
    en = 1'b0;
    step();
    chk("abort_idle", busy, 0);
    chk("abort_valid", avg_valid, 0);
    chk("abort_out_kept", avg_out, 10);
    repeat (450) step();
    chk("abort_quiet", avg_valid, 0);
    en = 1'b1;
    wait_valid(0, 500, cnt);
    chk("reen_lat", cnt, 402);
    chk("reen_avg", avg_out, 10);

    // avg_ack tied high: one-cycle pulses, measurement resumes right after ack
    avg_ack = 1'b1;
    step();
    chk("pulse1_width", avg_valid, 0);
    chk("pulse1_busy", busy, 1);
    wait_valid(0, 500, cnt);
    chk("pulse_gap", cnt, 401);
    chk("pulse2_avg", avg_out, 10);
    step();
    chk("pulse2_width", avg_valid, 0);
    en = 1'b0;
    step();
    step();
    avg_ack = 1'b0;
    chk("pulse_idle", busy, 0);

    // Reset while in HOLD
    en = 1'b1;
    wait_valid(0, 500, cnt);
    chk("prehold_lat", cnt, 402);
    rst_n = 1'b0;
    step();
    chk("rsthold_out", avg_out, 0);
    chk("rsthold_valid", avg_valid, 0);
    chk("rsthold_ovf", overflow, 0);
    chk("rsthold_busy", busy, 0);
    repeat (20) step();
    rst_n = 1'b1;
    wait_valid(0, 500, cnt);
    chk("postrst_lat", cnt, 402);
    chk("postrst_avg", avg_out, 10);

    // Reset mid-window
    avg_ack = 1'b1;
    step();
    avg_ack = 1'b0;
    repeat (150) step();
    chk("midwin_busy", busy, 1);
    rst_n = 1'b0;
    step();
    chk("rstmid_out", avg_out, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_valid", avg_valid, 0);
    rst_n = 1'b1;
    en    = 1'b0;
    step();

    // 4-bit instance: 25 edges per window saturate at 15
    osc_half = 2;
    osc_cnt  = 0;
    repeat (10) step();
    en4 = 1'b1;
    wait_valid(1, 500, cnt);
    chk("sat_lat", cnt, 402);
    chk("sat_avg", avg4, 15);
    chk("sat_ovf", ovf4, 1);
    chk("sat_busy", busy4, 1);
    en4  = 1'b0;
    ack4 = 1'b1;
    step();
    ack4 = 1'b0;
    chk("sat_ack_valid", valid4, 0);
    chk("sat_ack_idle", busy4, 0);

    // Clean run, period 20: 5 edges per window
    osc_half = 10;
    osc_cnt  = 0;
    repeat (30) step();
    en4 = 1'b1;
    wait_valid(1, 500, cnt);
    chk("clean_lat", cnt, 402);
    chk("clean_avg", avg4, 5);
    chk("clean_ovf", ovf4, 0);
    en4 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ring_osc_window_avg.md
# ring_osc_window_avg

Gated-window frequency meter that sits directly upstream of the hysteresis comparator and the UART send path. It takes the selected ring-oscillator output, which is asynchronous to clk_in, and counts its rising edges over fixed windows of clk_in cycles. It averages 2^AVG_LOG2 consecutive windows and presents the result as a held sample with a valid/ack handshake. Downstream blocks compare this sample against thresholds or serialise it.

## Interface
- WIDTH, 16, width of per-window edge count and of avg_out
- WINDOW_CYCLES, 1000, clk_in cycles per measurement window (>= 2)
- AVG_LOG2, 3, log2 of windows averaged per result (0 allowed: no averaging)

Ports:
- clk_in  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- en  in  1  measurement enable, level
- osc_in  in  1  ring-oscillator output, asynchronous to clk_in
- avg_ack  in  1  consumer accepts avg_out; sampled only while avg_valid=1
- avg_out  out  WIDTH  floor average of edge counts; held until next result
- avg_valid  out  1  result available
- overflow  out  1  at least one window in the current result saturated
- busy  out  1  high in WINDOW or HOLD state

## Operation
- osc_in passes through a 2-flop synchronizer, then a third flop for edge detection. edge = sync & ~prev.
- Edges are countable only when the osc_in period exceeds 2 clk_in cycles; faster inputs alias. This is documented, not detected.
- FSM states: IDLE, WINDOW, HOLD.
- IDLE: counters and accumulator are cleared. en=1 → WINDOW. avg_out is retained.
- WINDOW:
  - cyc_cnt runs 0..WINDOW_CYCLES-1.
  - Each edge increments win_cnt. win_cnt saturates at 2^WIDTH-1; an edge while saturated sets overflow_pend.
  - On the cycle with cyc_cnt = WINDOW_CYCLES-1, an edge in that cycle is included. On the next cycle:
    - acc += win_cnt. acc is WIDTH+AVG_LOG2 bits and cannot overflow.
    - win_cnt ← 0 and win_idx++.
  - When win_idx reaches 2^AVG_LOG2, the block loads avg_out ← acc >> AVG_LOG2, overflow ← overflow_pend and avg_valid ← 1. It then clears acc, win_idx and overflow_pend and enters HOLD.
- HOLD: no counting; edges are dropped.
  - On avg_ack=1, avg_valid ← 0 on the next edge. The FSM goes to WINDOW if en=1, otherwise IDLE.
- en=0 in WINDOW aborts to IDLE on the next edge. The partial window and accumulator are discarded. avg_out, avg_valid and overflow are unchanged.
- en=0 in HOLD has no effect until ack. The result is never lost.
- avg_ack while avg_valid=0 is ignored.
- Reset values: avg_out=0, avg_valid=0, overflow=0, busy=0, state IDLE. Synchronizer flops=0, all counters=0.

## Timing
- osc_in rising edge to counted: 3 clk_in cycles (2 sync + edge flop).
- Window length is exactly WINDOW_CYCLES clk_in cycles. The accumulate cycle also starts cyc_cnt=0 of the next window, so there is no dead cycle between windows.
- en rising in IDLE: WINDOW state is active on the next edge. The first counted cycle is that cycle.
- Result latency: avg_valid rises 1 cycle after the final cycle of window 2^AVG_LOG2. With constant en that is 2^AVG_LOG2 × WINDOW_CYCLES + 2 cycles after en rises.
- Handshake rules:
  - avg_out and overflow are stable while avg_valid=1.
  - Ack in cycle N gives avg_valid=0 in N+1 and measurement resumes in N+1.
  - With avg_ack held high, avg_valid is a 1-cycle pulse per result.
- Reset mid-operation takes effect on the next edge from any state. A pending result is discarded.

## Test plan
- Use WIDTH=16, WINDOW_CYCLES=100, AVG_LOG2=2 unless stated. osc_in toggles every 5 clk_in cycles (period 10) and en=1 → avg_valid rises 402 cycles after en. avg_out ∈ {9,10}, overflow=0, busy=1.
- Floor rounding: drive exactly 10, 11, 11, 11 edges in the four windows (gapped bursts) → avg_out=10 (43>>2), not 11.
- Overflow with WIDTH=4, osc period 4 cycles (25 edges per window) → avg_out=15, overflow=1. The next clean run with period 20 gives 5 edges per window → avg_out=5, overflow=0.
- Abort: deassert en at cycle 250 of a run → avg_valid stays 0, state IDLE and the previous avg_out is retained. Re-enable → first result appears 402 cycles later.
- Handshake: withhold avg_ack for 500 cycles with en=0 → avg_valid and avg_out stay stable and busy=1. Ack → avg_valid=0 next cycle and IDLE. With avg_ack tied high → one-cycle valid pulses every 401 cycles.
- Reset: assert rst_n=0 in HOLD and mid-WINDOW → next cycle all outputs are 0 and state IDLE. No edges are counted while rst_n=0 with osc_in toggling.
